output_port_arbiter: RTL and testbench
======================================

// Module: output_port_arbiter
// PURPOSE
//  Shares one leaf-to-BFT packet lane between NUM_PORTS output-port FIFOs. Round-robin grants with a burst
//  cap drive each port's rd_en_sel; the returning packets are muxed into a small skid FIFO that absorbs
//  lane backpressure. Sits in the leaf interface between the output-port bank and the BFT switch.
// PARAMETERS
//  NUM_PORTS    7   output ports arbitrated (2..16)
//  PACKET_BITS  97  packet width, MSB = valid bit
//  MAX_BURST    4   max consecutive grants to one port before forced rotation (>=1)
//  SKID_DEPTH   4   output skid FIFO entries (power of 2, >=4)
// PORTS
//  clk_bft      in   1                      BFT clock; the only clock
//  reset_bft_n  in   1                      asynchronous, active-low reset
//  port_empty   in   NUM_PORTS              per-port FIFO empty
//  port_credit  in   NUM_PORTS              per-port downstream freespace nonzero
//  port_pkt_in  in   NUM_PORTS*PACKET_BITS  per-port internal_out; port i at [i*PACKET_BITS +: PACKET_BITS]
//  rd_en_sel    out  NUM_PORTS              registered one-hot read select
//  pkt_out      out  PACKET_BITS            packet to BFT switch (skid FIFO head)
//  pkt_out_vld  out  1                      pkt_out valid
//  pkt_out_rdy  in   1                      switch accepts pkt_out this cycle
//  grant_idx    out  $clog2(NUM_PORTS)      index of current/last granted port
//  proto_err    out  1                      sticky: granted port returned MSB=0
//  pkt_cnt      out  32                     forwarded packets (OUTARB_PERF_CNT_EN)
//  stall_cnt    out  32                     cycles pkt_out_vld && !pkt_out_rdy (OUTARB_PERF_CNT_EN)
// BEHAVIOUR
//  Reset: every output 0; rr_ptr=0, burst_cnt=0, state IDLE, skid empty, outstanding=0. Asserting
//   reset_bft_n low mid-burst drops in-flight packets and skid contents immediately.
//  req[i] = !port_empty[i] && port_credit[i], sampled on the current cycle.
//  Slot rule: reserved = skid_count + outstanding (reads issued whose data has not been pushed, 0..2).
//   A grant may be registered for the next cycle only if reserved < SKID_DEPTH. Pops this cycle are not
//   credited (conservative). Guarantees the skid never overflows; full rate at SKID_DEPTH=4, rdy=1.
//  FSM: IDLE - no grant. If any req and slot available: pick first requesting i from rr_ptr cyclically,
//   rd_en_sel<=1<<i, grant_idx<=i, burst_cnt<=1, go GRANT. Otherwise rd_en_sel<=0.
//   GRANT - if req[grant_idx] && burst_cnt<MAX_BURST && slot: same port again, burst_cnt++.
//   Else if another req (or same port after cap, when it is the only requester) && slot: rotate,
//   rr_ptr<=grant_idx+1 mod NUM_PORTS, pick per IDLE rule, burst_cnt<=1. Else if !slot: rd_en_sel<=0,
//   stay GRANT, burst_cnt held (stall cycles do not count). Else (no req): rd_en_sel<=0,
//   rr_ptr<=grant_idx+1, go IDLE.
//  Latency: rd_en_sel high in cycle t -> port packet on port_pkt_in in t+1 -> pushed at end of t+1
//   -> pkt_out_vld at t+2 if skid was empty. Capture uses grant index delayed one cycle (sel_q).
//  Push only if sel_q valid and port_pkt_in[sel_q] MSB=1; if MSB=0 (port gated the read internally) drop
//   nothing, release the reservation, set proto_err (cleared only by reset).
//  Skid: pkt_out = head, pkt_out_vld = !empty; pop on vld && rdy; simultaneous push+pop keeps count;
//   pointers wrap mod SKID_DEPTH. pkt_out holds stable while vld && !rdy.
//  Only one bit of rd_en_sel is ever high; it never rises for a port whose req was 0 that cycle.
// CONFIGURATION
//  OUTARB_PERF_CNT_EN defined: pkt_cnt increments on each pop, stall_cnt on each vld && !rdy cycle;
//   both 32-bit wrapping, reset to 0.
//  Not defined: counter logic absent; pkt_cnt and stall_cnt tied to 0.
// TESTING
//  1 Port 2 only, 6 pkts, rdy=1 -> grants 2,2,2,2 then 2 again next cycle; 6 pkts out in order, first at t+2.
//  2 Ports 0,3,5 always req, MAX_BURST=4 -> grant_idx sequence 0x4,3x4,5x4,0...; no port starved.
//  3 All ports req, pkt_out_rdy=0 -> exactly SKID_DEPTH reads issued then rd_en_sel=0; rdy=1 resumes, no loss.
//  4 Grant port 1 while port 1 returns MSB=0 -> no push, proto_err=1, reservation freed, arbitration continues.
//  5 Reset low mid-burst with 3 in skid -> next cycle all outputs 0, pkt_out_vld=0, first grant to port 0.
//  6 With OUTARB_PERF_CNT_EN, 10 pkts, rdy low 5 cycles while vld -> pkt_cnt=10, stall_cnt=5.

Source files
------------

// File: rtl/output_port_arbiter_if.sv
// Packet lane from the output-port arbiter to the BFT switch.
// Master drives packet and valid, slave returns ready.
interface output_port_arbiter_if #(
  parameter int PACKET_BITS = 97
);
  logic [PACKET_BITS-1:0] pkt_out;
  logic                   pkt_out_vld;
  logic                   pkt_out_rdy;

  modport master (
    output pkt_out,
    output pkt_out_vld,
    input  pkt_out_rdy
  );

  modport slave (
    input  pkt_out,
    input  pkt_out_vld,
    output pkt_out_rdy
  );
endinterface

// File: rtl/output_port_arbiter.sv
// Round-robin, burst-capped arbiter sharing one BFT lane among output ports.
// Define OUTARB_PERF_CNT_EN to build the pkt_cnt/stall_cnt counters.
module output_port_arbiter #(
  parameter int NUM_PORTS   = 7,
  parameter int PACKET_BITS = 97,
  parameter int MAX_BURST   = 4,
  parameter int SKID_DEPTH  = 4,
  localparam int GW = $clog2(NUM_PORTS),
  localparam int PW = $clog2(SKID_DEPTH),
  localparam int CW = PW + 2,
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                           clk_bft,
  input  logic                           reset_bft_n,
  input  logic [NUM_PORTS-1:0]           port_empty,
  input  logic [NUM_PORTS-1:0]           port_credit,
  input  logic [NUM_PORTS*PACKET_BITS-1:0] port_pkt_in,
  output logic [NUM_PORTS-1:0]           rd_en_sel,
  output_port_arbiter_if.master          lane,
  output logic [GW-1:0]                  grant_idx,
  output logic                           proto_err,
  output logic [31:0]                    pkt_cnt,
  output logic [31:0]                    stall_cnt
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_e;

  state_e                 state_q, state_d;
  logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [BW-1:0]          burst_q, burst_d;
  logic [NUM_PORTS-1:0]   rd_en_q, rd_en_d;
  logic                   sel_vld_q, sel_vld_d;
  logic [GW-1:0]          sel_idx_q, sel_idx_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   perr_q, perr_d;
  logic [PACKET_BITS-1:0] mem_q [SKID_DEPTH];

  logic [NUM_PORTS-1:0]   req;
  logic                   any_req;
  logic                   req_cur;
  logic [CW-1:0]          reserved;
  logic                   slot;
  logic [GW-1:0]          nxt_ptr;
  logic [GW-1:0]          pick_idle;
  logic [GW-1:0]          pick_rot;
  logic [PACKET_BITS-1:0] pkt_sel;
  logic                   push;
  logic                   pop;
  logic                   empty;

  function automatic logic [NUM_PORTS-1:0] oh(
    input logic [GW-1:0] i
  );
    return NUM_PORTS'(1) << i;
  endfunction

  // first requester at or after start, wrapping
  function automatic logic [GW-1:0] pick(
    input logic [NUM_PORTS-1:0] r,
    input logic [GW-1:0]        start
  );
    logic [GW-1:0] res;
    logic [GW-1:0] ix;
    logic          found;
    int            idx;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      ix = GW'(idx);
      if (!found && r[ix]) begin
        found = 1'b1;
        res   = ix;
      end
    end
    return res;
  endfunction

  always_comb begin
    req     = ~port_empty & port_credit;
    any_req = |req;
    req_cur = |(req & oh(grant_q));
    nxt_ptr = (grant_q == GW'(NUM_PORTS - 1)) ?
              '0 : grant_q + GW'(1);
    pick_idle = pick(req, rr_ptr_q);
    pick_rot  = pick(req, nxt_ptr);
  end

  // reads issued whose data has not reached the skid yet
  always_comb begin
    reserved = cnt_q
             + CW'(|rd_en_q)
             + CW'(sel_vld_q);
    slot = reserved < CW'(SKID_DEPTH);
  end

  always_comb begin
    pkt_sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_idx_q == GW'(i)) begin
        pkt_sel = port_pkt_in[i*PACKET_BITS +: PACKET_BITS];
      end
    end
  end

  always_comb begin
    empty = (cnt_q == '0);
    push  = sel_vld_q && pkt_sel[PACKET_BITS-1];
    pop   = !empty && lane.pkt_out_rdy;
    perr_d = perr_q
           | (sel_vld_q && !pkt_sel[PACKET_BITS-1]);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    sel_vld_d = |rd_en_q;
    sel_idx_d = grant_q;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    burst_d  = burst_q;
    rd_en_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (any_req && slot) begin
          grant_d = pick_idle;
          rd_en_d = oh(pick_idle);
          burst_d = BW'(1);
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (req_cur && slot &&
            burst_q < BW'(MAX_BURST)) begin
          rd_en_d = oh(grant_q);
          burst_d = burst_q + BW'(1);
        end else if (any_req && slot) begin
          rr_ptr_d = nxt_ptr;
          grant_d  = pick_rot;
          rd_en_d  = oh(pick_rot);
          burst_d  = BW'(1);
        end else if (!slot) begin
          // stall: keep burst count, stay put
          state_d = S_GRANT;
        end else begin
          rr_ptr_d = nxt_ptr;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_bft or negedge reset_bft_n) begin
    if (!reset_bft_n) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      burst_q   <= '0;
      rd_en_q   <= '0;
      sel_vld_q <= 1'b0;
      sel_idx_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      burst_q   <= burst_d;
      rd_en_q   <= rd_en_d;
      sel_vld_q <= sel_vld_d;
      sel_idx_q <= sel_idx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      perr_q    <= perr_d;
    end
  end

  always_ff @(posedge clk_bft) begin
    if (push) mem_q[wr_ptr_q] <= pkt_sel;
  end

  assign rd_en_sel        = rd_en_q;
  assign grant_idx        = grant_q;
  assign proto_err        = perr_q;
  assign lane.pkt_out_vld = !empty;
  assign lane.pkt_out     = empty ? '0 : mem_q[rd_ptr_q];

`ifdef OUTARB_PERF_CNT_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    pkt_cnt_d   = pkt_cnt_q + 32'(pop);
    stall_cnt_d = stall_cnt_q
                + 32'(!empty && !lane.pkt_out_rdy);
  end

  always_ff @(posedge clk_bft or negedge reset_bft_n) begin
    if (!reset_bft_n) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pkt_cnt   = pkt_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign pkt_cnt   = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: table of first-grant vectors plus
// scoreboarded multi-cycle sequences (burst, rotation, stall, reset).
module tb_output_port_arbiter;
  localparam int NP = 7;
  localparam int PB = 97;
  localparam int GW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NP-1:0]    port_empty, port_credit, rd_en_sel;
  logic [NP*PB-1:0] port_pkt_in;
  logic [GW-1:0]    grant_idx;
  logic             proto_err;
  logic [31:0]      pkt_cnt, stall_cnt;

  output_port_arbiter_if #(.PACKET_BITS(PB)) lane();

  output_port_arbiter #(
    .NUM_PORTS(NP), .PACKET_BITS(PB),
    .MAX_BURST(4), .SKID_DEPTH(4)
  ) dut (
    .clk_bft(clk),
    .reset_bft_n(rst_n),
    .port_empty(port_empty),
    .port_credit(port_credit),
    .port_pkt_in(port_pkt_in),
    .rd_en_sel(rd_en_sel),
    .lane(lane.master),
    .grant_idx(grant_idx),
    .proto_err(proto_err),
    .pkt_cnt(pkt_cnt),
    .stall_cnt(stall_cnt)
  );

  // port FIFO model: registered read data, empty looks ahead one read
  int          cnt [NP];
  int          add [NP];
  bit          bad [NP];
  int          seq [NP];
  logic [PB-1:0] pin [NP];
  bit          manual;
  logic [NP-1:0] man_empty, man_credit, mdl_empty;

  function automatic logic [PB-1:0] mk(input int p, input int s);
    logic [PB-1:0] v;
    v = '0;
    v[PB-1]  = 1'b1;
    v[87:80] = 8'(p);
    v[63:32] = ~32'(s);
    v[31:0]  = 32'(s);
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NP; i++) begin
        cnt[i] <= 0;
        pin[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (rd_en_sel[i] && !bad[i] && cnt[i] > 0) begin
          pin[i] <= mk(i, seq[i]);
          seq[i] <= seq[i] + 1;
          cnt[i] <= cnt[i] + add[i] - 1;
        end else begin
          pin[i] <= '0;
          cnt[i] <= cnt[i] + add[i];
        end
      end
    end
  end

  always_comb begin
    mdl_empty = '0;
    port_pkt_in = '0;
    for (int i = 0; i < NP; i++) begin
      mdl_empty[i] = (cnt[i] == 0) ||
                     (cnt[i] == 1 && rd_en_sel[i]);
      port_pkt_in[i*PB +: PB] = pin[i];
    end
    port_empty  = manual ? man_empty : mdl_empty;
    port_credit = manual ? man_credit : '1;
  end

  int n_cmp, n_mis;
  logic [PB-1:0] sb [$];
  logic [GW-1:0] gq [$];
  int cyc, first_rd, last_rd, first_vld, first_g;
  int n_out, n_rd, n_stall;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    logic [NP-1:0] req_prev;
    logic [PB-1:0] prev_out;
    logic [PB-1:0] e;
    bit prev_stall;
    req_prev   = '0;
    prev_out   = '0;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sb.delete();
        req_prev   = '0;
        prev_stall = 1'b0;
      end else begin
        for (int i = 0; i < NP; i++)
          if (pin[i][PB-1]) sb.push_back(pin[i]);
        chk("onehot", 128'($onehot0(rd_en_sel)), 1);
        chk("req_gate", 128'(rd_en_sel & ~req_prev), 0);
        if (|rd_en_sel) begin
          n_rd++;
          gq.push_back(grant_idx);
          if (first_rd < 0) begin
            first_rd = cyc;
            first_g  = int'(grant_idx);
          end
          last_rd = cyc;
        end
        if (lane.pkt_out_vld && first_vld < 0)
          first_vld = cyc;
        if (lane.pkt_out_vld && lane.pkt_out_rdy) begin
          n_out++;
          chk("sb_nonempty", 128'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pkt_data", 128'(lane.pkt_out), 128'(e));
          end
        end
        if (prev_stall)
          chk("pkt_hold", 128'(lane.pkt_out),
              128'(prev_out));
        prev_stall = lane.pkt_out_vld && !lane.pkt_out_rdy;
        if (prev_stall) n_stall++;
        prev_out = lane.pkt_out;
        req_prev = ~port_empty & port_credit;
      end
    end
  endtask

  task automatic clr_stats();
    first_rd  = -1;
    last_rd   = -1;
    first_vld = -1;
    first_g   = -1;
    n_out     = 0;
    n_rd      = 0;
    n_stall   = 0;
    gq.delete();
  endtask

  task automatic do_reset();
    manual = 1'b0;
    lane.pkt_out_rdy = 1'b1;
    for (int i = 0; i < NP; i++) begin
      add[i] = 0;
      bad[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clr_stats();
  endtask

  task automatic load(input logic [NP-1:0] m, input int n);
    for (int i = 0; i < NP; i++) if (m[i]) add[i] = n;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) add[i] = 0;
  endtask

  function automatic bit model_idle();
    bit r;
    r = 1'b1;
    for (int i = 0; i < NP; i++)
      if (cnt[i] != 0 || pin[i][PB-1]) r = 1'b0;
    return r;
  endfunction

  task automatic wait_drain(input string nm, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk);
      #1;
      done = (sb.size() == 0) && !lane.pkt_out_vld &&
             (rd_en_sel == '0) && model_idle();
    end
    chk({nm, "_drained"}, 128'(done), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [NP-1:0] empty;
    logic [NP-1:0] credit;
    logic [NP-1:0] rd;
    logic [GW-1:0] g;
  } vec_t;
  vec_t vec [7];

  initial begin
    int ports [3];
    bit seen;
    n_cmp = 0;
    n_mis = 0;
    cyc = 0;
    manual = 1'b0;
    man_empty = '1;
    man_credit = '0;
    lane.pkt_out_rdy = 1'b1;
    for (int i = 0; i < NP; i++) begin
      add[i] = 0;
      bad[i] = 1'b0;
      seq[i] = 0;
    end
    clr_stats();
    fork
      monitor();
    join_none

    vec[0] = '{7'b1111011, 7'b1111111, 7'b0000100, 3'd2};
    vec[1] = '{7'b0000000, 7'b1000000, 7'b1000000, 3'd6};
    vec[2] = '{7'b0000001, 7'b0000011, 7'b0000010, 3'd1};
    vec[3] = '{7'b0000000, 7'b0000000, 7'b0000000, 3'd0};
    vec[4] = '{7'b1111111, 7'b1111111, 7'b0000000, 3'd0};
    vec[5] = '{7'b0101010, 7'b1111110, 7'b0000100, 3'd2};
    vec[6] = '{7'b0000000, 7'b1111111, 7'b0000001, 3'd0};

    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_rd_en", 128'(rd_en_sel), 0);
    chk("rst_grant", 128'(grant_idx), 0);
    chk("rst_vld", 128'(lane.pkt_out_vld), 0);
    chk("rst_pkt", 128'(lane.pkt_out), 0);
    chk("rst_perr", 128'(proto_err), 0);
    chk("rst_pktcnt", 128'(pkt_cnt), 0);
    chk("rst_stallcnt", 128'(stall_cnt), 0);

    for (int k = 0; k < 7; k++) begin
      do_reset();
      manual = 1'b1;
      man_empty = vec[k].empty;
      man_credit = vec[k].credit;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_rd_en", k),
          128'(rd_en_sel), 128'(vec[k].rd));
      chk($sformatf("vec%0d_grant", k),
          128'(grant_idx), 128'(vec[k].g));
    end

    // single port, 6 packets: contiguous grants, latency 2
    do_reset();
    load(7'b0000100, 6);
    wait_drain("t1", 100);
    chk("t1_reads", 128'(gq.size()), 6);
    for (int k = 0; k < gq.size(); k++)
      chk($sformatf("t1_g%0d", k), 128'(gq[k]), 2);
    chk("t1_contig", 128'(last_rd - first_rd), 5);
    chk("t1_latency", 128'(first_vld - first_rd), 2);
    chk("t1_out", 128'(n_out), 6);
    chk("t1_perr", 128'(proto_err), 0);

    // three ports always requesting: 4-grant bursts in rotation
    do_reset();
    ports = '{0, 3, 5};
    load(7'b0101001, 40);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(posedge clk);
      #1;
      seen = (gq.size() >= 24);
    end
    chk("t2_seen24", 128'(seen), 1);
    chk("t2_fullrate", 128'(last_rd - first_rd),
        128'(gq.size() - 1));
    for (int k = 0; k < 24 && k < gq.size(); k++)
      chk($sformatf("t2_g%0d", k), 128'(gq[k]),
          128'(ports[(k / 4) % 3]));
    wait_drain("t2", 400);
    chk("t2_out", 128'(n_out), 120);

    // lane blocked: exactly 4 reads, then resume with no loss
    do_reset();
    lane.pkt_out_rdy = 1'b0;
    load(7'b1111111, 5);
    repeat (12) @(posedge clk);
    #1;
    chk("t3_reads", 128'(n_rd), 4);
    chk("t3_rd_idle", 128'(rd_en_sel), 0);
    chk("t3_vld", 128'(lane.pkt_out_vld), 1);
    lane.pkt_out_rdy = 1'b1;
    wait_drain("t3", 200);
    chk("t3_out", 128'(n_out), 35);

    // port returns MSB=0 while granted
    do_reset();
    bad[1] = 1'b1;
    load(7'b0000010, 5);
    repeat (6) @(posedge clk);
    #1;
    chk("t4_perr", 128'(proto_err), 1);
    chk("t4_nopush", 128'(lane.pkt_out_vld), 0);
    bad[1] = 1'b0;
    wait_drain("t4", 100);
    chk("t4_out", 128'(n_out), 5);
    chk("t4_perr_sticky", 128'(proto_err), 1);

    // reset mid-burst with 3 packets in the skid
    do_reset();
    lane.pkt_out_rdy = 1'b0;
    load(7'b0010000, 10);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_pre_vld", 128'(lane.pkt_out_vld), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rd_en", 128'(rd_en_sel), 0);
    chk("t5_vld", 128'(lane.pkt_out_vld), 0);
    chk("t5_pkt", 128'(lane.pkt_out), 0);
    chk("t5_grant", 128'(grant_idx), 0);
    chk("t5_perr", 128'(proto_err), 0);
    chk("t5_pktcnt", 128'(pkt_cnt), 0);
    chk("t5_stallcnt", 128'(stall_cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clr_stats();
    lane.pkt_out_rdy = 1'b1;
    load(7'b0010001, 3);
    wait_drain("t5", 100);
    chk("t5_first_g", 128'(first_g), 0);
    chk("t5_out", 128'(n_out), 6);

    // performance counters: 10 packets, 5 stalled cycles
    do_reset();
    load(7'b1000000, 10);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = lane.pkt_out_vld;
    end
    chk("t6_vld_seen", 128'(seen), 1);
    @(posedge clk);
    #1 lane.pkt_out_rdy = 1'b0;
    repeat (5) @(posedge clk);
    #1 lane.pkt_out_rdy = 1'b1;
    wait_drain("t6", 100);
    chk("t6_out", 128'(n_out), 10);
    chk("t6_stalls_seen", 128'(n_stall), 5);
`ifdef OUTARB_PERF_CNT_EN
    chk("t6_pkt_cnt", 128'(pkt_cnt), 10);
    chk("t6_stall_cnt", 128'(stall_cnt), 5);
`else
    chk("t6_pkt_cnt", 128'(pkt_cnt), 0);
    chk("t6_stall_cnt", 128'(stall_cnt), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
